// File: rtl/ew_sim_top.sv
// Electronic-warfare threat-response controller: classifies jamming/spoofing,
// runs the response FSM, hops channels and keeps a small log of seen threats.
module ew_sim_top #(
    parameter logic [7:0] JAM_THRESH      = 8'd200,
    parameter logic [7:0] SPOOF_SIG       = 8'd123,
    parameter logic [7:0] AUTH_KEY        = 8'hA5,
    parameter int         AUTH_TIMEOUT    = 4,
    parameter int         RECOVERY_CYCLES = 2,
    parameter int         JAM_HOLD        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] signal_in,
    input  logic [7:0] command_in,
    input  logic [7:0] ch0,
    input  logic [7:0] ch1,
    input  logic [7:0] ch2,
    input  logic [7:0] ch3,
    output logic [2:0] fsm_state,
    output logic [1:0] comm_channel,
    output logic       system_fault
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_JAMMED   = 3'd1;
    localparam logic [2:0] ST_SPOOF    = 3'd2;
    localparam logic [2:0] ST_AUTH     = 3'd3;
    localparam logic [2:0] ST_RECOVERY = 3'd4;
    localparam logic [2:0] ST_LOGGING  = 3'd5;
    localparam logic [2:0] ST_KNOWN    = 3'd6;

    localparam logic [3:0] JAM_LAST  = 4'(JAM_HOLD - 1);
    localparam logic [3:0] AUTH_LAST = 4'(AUTH_TIMEOUT - 1);
    localparam logic [3:0] REC_LAST  = 4'(RECOVERY_CYCLES - 1);

    logic [2:0] state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [7:0] sig_reg, sig_next;
    logic [1:0] chan_reg, chan_next;
    logic       fault_reg, fault_next;
    logic [7:0] log_mem [0:3];
    logic [3:0] log_valid_reg;
    logic [1:0] wr_ptr_reg;
    logic       log_wr;

    logic       jam, spoof, threat, known;
    logic [3:0] hit_in, hit_sig;
    logic [3:0] ch_en;
    logic [1:0] hop_chan;

    assign jam    = (signal_in >= JAM_THRESH);
    assign spoof  = (signal_in == SPOOF_SIG) && !jam;
    assign threat = jam || spoof;
    assign known  = threat && (|hit_in);
    assign ch_en  = {ch3 != 8'h00, ch2 != 8'h00, ch1 != 8'h00, ch0 != 8'h00};

    // Parallel compare against every log entry: live input and captured signature.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_log_cmp
            assign hit_in[gi]  = log_valid_reg[gi] && (log_mem[gi] == signal_in);
            assign hit_sig[gi] = log_valid_reg[gi] && (log_mem[gi] == sig_reg);
        end
    endgenerate

    // Next enabled channel after the current one; stays put if none other is enabled.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        hop_chan = chan_reg;
        found    = 1'b0;
        idx      = chan_reg;
        for (int k = 1; k < 4; k++) begin
            idx = chan_reg + 2'(k);
            if (!found && ch_en[idx]) begin
                hop_chan = idx;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sig_next   = sig_reg;
        chan_next  = chan_reg;
        fault_next = fault_reg;
        log_wr     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (threat) begin
                    sig_next = signal_in;
                    cnt_next = 4'd0;
                    if (jam) chan_next = hop_chan;
                    if (known)    state_next = ST_KNOWN;
                    else if (jam) state_next = ST_JAMMED;
                    else          state_next = ST_SPOOF;
                end
            end
            ST_JAMMED: begin
                if (!jam) begin
                    state_next = ST_RECOVERY;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == JAM_LAST) begin
                    state_next = ST_LOGGING;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_SPOOF: begin
                state_next = ST_AUTH;
                cnt_next   = 4'd0;
            end
            ST_AUTH: begin
                // Key is checked first so it wins on the timeout cycle.
                if (command_in == AUTH_KEY) begin
                    state_next = ST_RECOVERY;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == AUTH_LAST) begin
                    state_next = ST_LOGGING;
                    fault_next = 1'b1;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_RECOVERY: begin
                if (cnt_reg == REC_LAST) begin
                    state_next = ST_LOGGING;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_LOGGING: begin
                state_next = ST_IDLE;
                log_wr     = !(|hit_sig);
            end
            ST_KNOWN: begin
                if (!threat) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            sig_reg       <= 8'd0;
            chan_reg      <= 2'd0;
            fault_reg     <= 1'b0;
            log_valid_reg <= 4'd0;
            wr_ptr_reg    <= 2'd0;
            for (int i = 0; i < 4; i++) log_mem[i] <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sig_reg   <= sig_next;
            chan_reg  <= chan_next;
            fault_reg <= fault_next;
            if (log_wr) begin
                log_mem[wr_ptr_reg]       <= sig_reg;
                log_valid_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg                <= wr_ptr_reg + 2'd1;
            end
        end
    end

    assign fsm_state    = state_reg;
    assign comm_channel = chan_reg;
    assign system_fault = fault_reg;

endmodule

// File: tb/tb_ew_sim_top.sv
// Directed bench for ew_sim_top: walks jam, spoof, known-threat, timeout and reset paths.
module tb_ew_sim_top;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] signal_in, command_in;
    logic [7:0] ch0, ch1, ch2, ch3;
    logic [2:0] fsm_state;
    logic [1:0] comm_channel;
    logic       system_fault;

    int tests_run = 0;
    int tests_failed = 0;

    ew_sim_top dut (
        .clk          (clk),
        .reset        (reset),
        .signal_in    (signal_in),
        .command_in   (command_in),
        .ch0          (ch0),
        .ch1          (ch1),
        .ch2          (ch2),
        .ch3          (ch3),
        .fsm_state    (fsm_state),
        .comm_channel (comm_channel),
        .system_fault (system_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp)
            $display("[TB] %s ok (%0d)", tag, obs);
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st,
                             input logic [1:0] ch, input logic flt);
        check({tag, ".state"}, 8'(fsm_state), 8'(st));
        check({tag, ".chan"},  8'(comm_channel), 8'(ch));
        check({tag, ".fault"}, 8'(system_fault), 8'(flt));
    endtask

    initial begin
        reset = 1'b0; signal_in = 8'd0; command_in = 8'd0;
        ch0 = 8'h08; ch1 = 8'h0F; ch2 = 8'h14; ch3 = 8'h19;
        tick(); tick();
        check_all("reset", 3'd0, 2'd0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_hold", 8'(fsm_state), 8'd0);
        end

        // Jamming at 220: hop 0->1, then recovery, logging, idle
        signal_in = 8'd220; command_in = 8'hFF;
        tick(); check_all("jam_enter", 3'd1, 2'd1, 1'b0);
        tick(); check("jam_c2", 8'(fsm_state), 8'd1);
        tick(); check("jam_c3", 8'(fsm_state), 8'd1);
        signal_in = 8'd0;
        tick(); check("rec1", 8'(fsm_state), 8'd4);
        tick(); check("rec2", 8'(fsm_state), 8'd4);
        tick(); check("log", 8'(fsm_state), 8'd5);
        tick(); check_all("idle_after_jam", 3'd0, 2'd1, 1'b0);

        // 220 is now known; ch2 disabled so hop 1->3
        ch2 = 8'h00; signal_in = 8'd220;
        tick(); check_all("known_enter", 3'd6, 2'd3, 1'b0);
        tick(); check("known_stay", 8'(fsm_state), 8'd6);
        signal_in = 8'd0;
        tick(); check("known_exit", 8'(fsm_state), 8'd0);

        // Spoof with key on 2nd auth cycle
        signal_in = 8'd123; command_in = 8'h00;
        tick(); check_all("spoof", 3'd2, 2'd3, 1'b0);
        signal_in = 8'd0;
        tick(); check("auth1", 8'(fsm_state), 8'd3);
        command_in = 8'hA5;
        tick(); check("auth_key_rec", 8'(fsm_state), 8'd4);
        command_in = 8'h00;
        tick(); check("key_rec2", 8'(fsm_state), 8'd4);
        tick(); check("key_log", 8'(fsm_state), 8'd5);
        tick(); check_all("key_idle", 3'd0, 2'd3, 1'b0);

        // 123 now logged: known, no hop since not jamming
        signal_in = 8'd123;
        tick(); check_all("known_spoof", 3'd6, 2'd3, 1'b0);
        signal_in = 8'd0;
        tick(); check("known_spoof_exit", 8'(fsm_state), 8'd0);

        // Reset clears the log, then spoof timeout
        reset = 1'b0;
        #1; check_all("reset2", 3'd0, 2'd0, 1'b0);
        tick(); reset = 1'b1;
        signal_in = 8'd123; command_in = 8'h00;
        tick(); check("to_spoof", 8'(fsm_state), 8'd2);
        signal_in = 8'd0;
        tick(); check("to_auth1", 8'(fsm_state), 8'd3);
        tick(); check("to_auth2", 8'(fsm_state), 8'd3);
        tick(); check("to_auth3", 8'(fsm_state), 8'd3);
        tick(); check_all("to_auth4", 3'd3, 2'd0, 1'b0);
        tick(); check_all("to_log", 3'd5, 2'd0, 1'b1);
        tick(); check_all("to_idle", 3'd0, 2'd0, 1'b1);

        // 255 held: 8 JAMMED cycles then forced logging (hop 0->1)
        signal_in = 8'd255;
        tick(); check_all("hold_enter", 3'd1, 2'd1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick(); check("hold_jam", 8'(fsm_state), 8'd1);
        end
        tick(); check("hold_log", 8'(fsm_state), 8'd5);
        signal_in = 8'd0;
        tick(); check_all("hold_idle", 3'd0, 2'd1, 1'b1);

        signal_in = 8'd255;
        tick(); check_all("known255", 3'd6, 2'd3, 1'b1);
        signal_in = 8'd0;
        tick(); check("known255_exit", 8'(fsm_state), 8'd0);

        // Enter JAMMED with 230 (hop 3->0), reset mid-state
        signal_in = 8'd230;
        tick(); check_all("jam230", 3'd1, 2'd0, 1'b1);
        tick();
        reset = 1'b0;
        #1; check_all("mid_reset", 3'd0, 2'd0, 1'b0);
        tick(); reset = 1'b1;
        signal_in = 8'd255;
        tick(); check_all("post_reset255", 3'd1, 2'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
